wait_time_calc: RTL and testbench

Parametrised, sequential successor to the fixed wait-time lookup in the smart bank queue manager.
- Computes estimated client wait time as SVC_TIME × ceil(pcount / tcount), with restoring division over PC_W cycles.
- Saturates the result and flags zero-teller requests.
- Sits between the people/teller counters and the display/report logic, and uses a start/busy/done handshake.

---
 rtl/sbqm_pkg.sv | 29 ++
 rtl/seq_divider.sv | 69 ++++++
 rtl/wait_time_calc.sv | 139 +++++++++++++
 tb/tb_wait_time_calc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// ============================================================================
//  Module      : sbqm_pkg
//  Description : Shared types and default sizing for the bank queue wait-time
//                calculator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sbqm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int unsigned c_DEF_TC_W     = 2;
    localparam int unsigned c_DEF_PC_W     = 3;
    localparam int unsigned c_DEF_WT_W     = 5;
    localparam int unsigned c_DEF_SVC_TIME = 3;

    // Largest value representable on a wt_w-bit wait-time bus
    function automatic int unsigned wt_max(input int unsigned wt_w);
        return (32'd1 << wt_w) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Restoring divider, one quotient bit per cycle, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int unsigned DVD_W = 3,
    parameter int unsigned DVS_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W:0]   remainder
);

    localparam int unsigned c_CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

    logic               busy_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [DVD_W-1:0]   quo_q;
    logic [DVS_W:0]     rem_q;
    logic [DVS_W-1:0]   dvs_q;

    logic [DVS_W:0]     w_rem_sh;
    logic [DVS_W:0]     w_rem_sub;
    logic               w_fits;

    // Remainder stays below the divisor, so its MSB is always free for the shift
    assign w_rem_sh  = {rem_q[DVS_W-1:0], quo_q[DVD_W-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, dvs_q};
    assign w_fits    = (w_rem_sh >= {1'b0, dvs_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (start && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= c_CNT_W'(DVD_W - 1);
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= w_fits ? w_rem_sub : w_rem_sh;
            quo_q <= (quo_q << 1) | DVD_W'(w_fits);
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

    // High during the final step; quotient/remainder are valid from the next cycle
    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

`default_nettype wire

// File: rtl/wait_time_calc.sv
// ============================================================================
//  Module      : wait_time_calc
//  Description : Wait time = SVC_TIME * ceil(pcount / tcount), saturated,
//                with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_time_calc
    import sbqm_pkg::*;
#(
    parameter int unsigned TC_W     = c_DEF_TC_W,
    parameter int unsigned PC_W     = c_DEF_PC_W,
    parameter int unsigned SVC_TIME = c_DEF_SVC_TIME,
    parameter int unsigned WT_W     = c_DEF_WT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TC_W-1:0] tcount,
    input  logic [PC_W-1:0] pcount,
    output logic            busy,
    output logic            done,
    output logic [WT_W-1:0] wtime,
    output logic            err,
    output logic            sat
);

    localparam int unsigned         c_PROD_W = PC_W + WT_W;
    localparam logic [c_PROD_W-1:0] c_WT_MAX = c_PROD_W'(wt_max(WT_W));

    state_e              state_q, state_d;
    logic                err_pend_q, err_pend_d;
    logic                done_q, done_d;
    logic [WT_W-1:0]     wtime_q, wtime_d;
    logic                err_q, err_d;
    logic                sat_q, sat_d;

    logic                w_tzero;
    logic                w_div_start;
    logic                w_div_done;
    logic [PC_W-1:0]     w_div_quo;
    logic [TC_W:0]       w_div_rem;
    logic [c_PROD_W-1:0] w_q_ceil;
    logic [c_PROD_W-1:0] w_prod;
    logic                w_sat;

    assign w_tzero = (tcount == '0);

    seq_divider #(
        .DVD_W (PC_W),
        .DVS_W (TC_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (pcount),
        .divisor   (tcount),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_pend_q <= err_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_pend_d = err_pend_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_pend_d = w_tzero;
                    state_d    = w_tzero ? FIN : DIV;
                end
            end
            DIV:     if (w_div_done) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        w_div_start = (state_q == IDLE) && start && !w_tzero;
    end

    // Round the quotient up, scale by service time, then clip to the bus
    assign w_q_ceil = c_PROD_W'(w_div_quo) + c_PROD_W'(|w_div_rem);
    assign w_prod   = w_q_ceil * c_PROD_W'(SVC_TIME);
    assign w_sat    = (w_prod > c_WT_MAX);

    always_comb begin
        done_d  = (state_q == FIN);
        wtime_d = wtime_q;
        err_d   = err_q;
        sat_d   = sat_q;
        if (state_q == FIN) begin
            if (err_pend_q) begin
                wtime_d = '0;
                err_d   = 1'b1;
                sat_d   = 1'b0;
            end else begin
                wtime_d = w_sat ? c_WT_MAX[WT_W-1:0] : w_prod[WT_W-1:0];
                err_d   = 1'b0;
                sat_d   = w_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            wtime_q <= '0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            done_q  <= done_d;
            wtime_q <= wtime_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
        end
    end

    assign done  = done_q;
    assign wtime = wtime_q;
    assign err   = err_q;
    assign sat   = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_wait_time_calc.sv
// ============================================================================
//  Module      : tb_wait_time_calc
//  Description : Self-checking bench for wait_time_calc (SVC_TIME 3 and 5).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wait_time_calc;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [1:0] tc_a, tc_b;
    logic [2:0] pc_a, pc_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [4:0] wt_a, wt_b;
    logic       err_a, err_b, sat_a, sat_b;

    int tests  = 0;
    int failed = 0;

    wait_time_calc dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tcount(tc_a), .pcount(pc_a),
        .busy(busy_a), .done(done_a), .wtime(wt_a), .err(err_a), .sat(sat_a)
    );

    wait_time_calc #(.SVC_TIME(5), .WT_W(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tcount(tc_b), .pcount(pc_b),
        .busy(busy_b), .done(done_b), .wtime(wt_b), .err(err_b), .sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int t;
        int p;
        int w;
        int e;
        int s;
        int lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: ceil division by plain arithmetic, then scale and clip
    function automatic void model(input int svc, input int t, input int p,
                                  output int w, output int e, output int s, output int lat);
        int q;
        int prod;
        if (t == 0) begin
            w = 0; e = 1; s = 0; lat = 2;
        end else begin
            q    = (p + t - 1) / t;
            prod = q * svc;
            e    = 0;
            lat  = 5;
            if (prod > 31) begin
                w = 31; s = 1;
            end else begin
                w = prod; s = 0;
            end
        end
    endfunction

    task automatic req(input int sel, input int t, input int p,
                       output int lat, output int w, output int e, output int s, output int bz);
        int k;
        @(negedge clk);
        if (sel == 0) begin
            start_a = 1'b1; tc_a = 2'(t); pc_a = 3'(p);
        end else begin
            start_b = 1'b1; tc_b = 2'(t); pc_b = 3'(p);
        end
        lat = -1; w = -1; e = -1; s = -1; bz = -1;
        k = 0;
        while (lat < 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (sel == 0 && done_a) begin
                lat = k; w = int'(wt_a); e = int'(err_a); s = int'(sat_a); bz = int'(busy_a);
            end else if (sel == 1 && done_b) begin
                lat = k; w = int'(wt_b); e = int'(err_b); s = int'(sat_b); bz = int'(busy_b);
            end
        end
    endtask

    task automatic run_and_check(input string tag, input int sel, input int t, input int p,
                                 input int ew, input int ee, input int es, input int elat);
        int lat, w, e, s, bz;
        req(sel, t, p, lat, w, e, s, bz);
        check({tag, " latency"}, lat, elat);
        check({tag, " wtime"}, w, ew);
        check({tag, " err"}, e, ee);
        check({tag, " sat"}, s, es);
        check({tag, " busy@done"}, bz, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        int   ndone;
        int   ew, ee, es, el;

        vecs[0]  = '{0, 1, 7, 21, 0, 0, 5};
        vecs[1]  = '{0, 2, 5,  9, 0, 0, 5};
        vecs[2]  = '{0, 3, 7,  9, 0, 0, 5};
        vecs[3]  = '{0, 3, 6,  6, 0, 0, 5};
        vecs[4]  = '{0, 0, 4,  0, 1, 0, 2};
        vecs[5]  = '{0, 1, 1,  3, 0, 0, 5};
        vecs[6]  = '{0, 0, 0,  0, 1, 0, 2};
        vecs[7]  = '{0, 3, 0,  0, 0, 0, 5};
        vecs[8]  = '{0, 2, 7, 12, 0, 0, 5};
        vecs[9]  = '{1, 1, 7, 31, 0, 1, 5};
        vecs[10] = '{1, 1, 0,  0, 0, 0, 5};
        vecs[11] = '{1, 1, 6, 30, 0, 0, 5};
        vecs[12] = '{1, 2, 7, 20, 0, 0, 5};
        vecs[13] = '{1, 3, 7, 15, 0, 0, 5};

        rst = 1'b1;
        start_a = 1'b0; tc_a = '0; pc_a = '0;
        start_b = 1'b0; tc_b = '0; pc_b = '0;
        @(negedge clk);
        check("reset busy",  int'(busy_a), 0);
        check("reset done",  int'(done_a), 0);
        check("reset wtime", int'(wt_a), 0);
        check("reset err",   int'(err_a), 0);
        check("reset sat",   int'(sat_a), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].t, vecs[i].p,
                          vecs[i].w, vecs[i].e, vecs[i].s, vecs[i].lat);
        end

        // Start held high: one result per 5 cycles; mid-calculation operand changes ignored
        @(negedge clk);
        start_a = 1'b1; tc_a = 2'd2; pc_a = 3'd3;
        ndone = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 2)  begin tc_a = 2'd1; pc_a = 3'd7; end
            if (k == 4)  begin tc_a = 2'd2; pc_a = 3'd3; end
            if (k == 16) start_a = 1'b0;
            if (done_a) begin
                ndone++;
                check("b2b done cycle", k, 5 * ndone);
                check("b2b wtime", int'(wt_a), 6);
            end
        end
        check("b2b result count", ndone, 4);

        // Reset in the middle of DIV aborts the calculation
        run_and_check("pre-reset", 0, 1, 7, 21, 0, 0, 5);
        @(negedge clk);
        start_a = 1'b1; tc_a = 2'd1; pc_a = 3'd7;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy",  int'(busy_a), 0);
        check("abort done",  int'(done_a), 0);
        check("abort wtime", int'(wt_a), 0);
        check("abort err",   int'(err_a), 0);
        check("abort sat",   int'(sat_a), 0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("abort no done", ndone, 0);
        run_and_check("post-reset", 0, 2, 5, 9, 0, 0, 5);

        // Randomised requests against the reference model
        for (int i = 0; i < 60; i++) begin
            int sel, t, p;
            sel = int'($urandom_range(0, 1));
            t   = int'($urandom_range(0, 3));
            p   = int'($urandom_range(0, 7));
            model((sel == 0) ? 3 : 5, t, p, ew, ee, es, el);
            run_and_check($sformatf("rnd%0d s%0d t%0d p%0d", i, sel, t, p), sel, t, p, ew, ee, es, el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
